// File: rtl/svm_cfg_arbiter.sv
// Round-robin arbiter that shares the SVM core cfg register port between NUM_REQ requesters.
// Optional macro SVM_CFG_ARB_HOST_PRIO_EN gives requester 0 (host) strict priority over the rest.
module svm_cfg_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int NUM_REGS   = 17,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [NUM_REQ-1:0]      req_rb_w,
  input  logic [NUM_REQ*16-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_gnt,
  output logic [NUM_REQ-1:0]      rsp_vld,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  input  logic                    cfg_locked,
  output logic                    cfg_req_vld,
  output logic                    cfg_data_rb_w,
  output logic [15:0]             cfg_addr,
  output logic [31:0]             cfg_data,
  input  logic                    cfg_data_rd_vld,
  input  logic [31:0]             cfg_rd_data
);

  localparam int          PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [16:0] REGS_W = 17'(NUM_REGS);
  localparam logic [7:0]  TO     = 8'(RD_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;

  typedef struct packed {
    logic        rb_w;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t [NUM_REQ-1:0] req_a;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_a[i] = {req_rb_w[i], req_addr[16*i +: 16], req_wdata[32*i +: 32]};
  end

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_q, rr_d;
  req_t          req_q, req_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_inc;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic          issue_err;

  // Search upward from rr_q with wrap; first requester found wins.
  always_comb begin
    int  idx;
    logic skip;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    skip      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`ifdef SVM_CFG_ARB_HOST_PRIO_EN
      skip = (idx == 0);
`else
      skip = 1'b0;
`endif
      if (!sel_found && !skip && req_vld[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
`ifdef SVM_CFG_ARB_HOST_PRIO_EN
    if (req_vld[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  assign issue_err = ({1'b0, req_q.addr} >= REGS_W) || (req_q.rb_w && cfg_locked);
  assign cnt_inc   = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      req_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          req_d   = req_a[sel_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_err) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else if (req_q.rb_w) begin
          err_d   = 1'b0;
          data_d  = '0;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (cfg_data_rd_vld) begin
          data_d  = cfg_rd_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (owner_q == PW'(NUM_REQ - 1)) rr_d = '0;
        else                             rr_d = owner_q + PW'(1);
`ifdef SVM_CFG_ARB_HOST_PRIO_EN
        // Host is served by priority, so the rotation never lands on it.
        if (rr_d == '0) rr_d = PW'(1);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_gnt     = '0;
    rsp_vld     = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    cfg_req_vld = 1'b0;
    case (state_q)
      IDLE:    if (sel_found && rst_n) req_gnt[sel_idx] = 1'b1;
      ISSUE:   cfg_req_vld = !issue_err;
      RESP: begin
        rsp_vld[owner_q] = 1'b1;
        rsp_data         = data_q;
        rsp_err          = err_q;
      end
      default: ;
    endcase
  end

  // Latched request only changes on grant, so these hold outside ISSUE.
  assign cfg_data_rb_w = req_q.rb_w;
  assign cfg_addr      = req_q.addr;
  assign cfg_data      = req_q.wdata;

endmodule

// File: doc/svm_cfg_arbiter.md
Name: svm_cfg_arbiter

Overview:
- Shares the single SVM core configuration register port between NUM_REQ requesters: host bus, debug port, and the internal batch sequencer.
- Round-robin arbitration; one transaction in flight at a time.
- Range-checks addresses and blocks writes once configuration is locked.
- Times out reads that are never answered and returns a per-requester response.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- NUM_REGS, 17, number of implemented cfg registers; valid addresses are 0..NUM_REGS-1.
- RD_TIMEOUT, 15, WAIT_RD cycles before a read is aborted with an error (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester request; held until granted
- req_rb_w  in  NUM_REQ  per-requester direction: 1 = write, 0 = read
- req_addr  in  NUM_REQ*16  packed addresses; requester i uses bits [16i+15:16i]
- req_wdata  in  NUM_REQ*32  packed write data; requester i uses bits [32i+31:32i]
- req_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rsp_vld  out  NUM_REQ  one-hot, one-cycle response pulse to the owner
- rsp_data  out  32  read data; 0 for writes and errors
- rsp_err  out  1  error flag, valid with rsp_vld
- cfg_locked  in  1  cfg-done bit; when 1, writes are rejected
- cfg_req_vld  out  1  downstream request strobe
- cfg_data_rb_w  out  1  downstream direction
- cfg_addr  out  16  downstream address
- cfg_data  out  32  downstream write data
- cfg_data_rd_vld  in  1  downstream read-valid
- cfg_rd_data  in  32  downstream read data

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; rr_ptr = 0; timeout counter = 0.
- Four states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any req_vld is set, select the first set bit searching upward from rr_ptr, with wrap.
  - Pulse req_gnt[sel] for that cycle.
  - Latch owner, rb_w, addr and wdata.
  - Go to ISSUE. With no requests, stay in IDLE.
- ISSUE, error case: if addr >= NUM_REGS, or (rb_w=1 and cfg_locked=1):
  - cfg_req_vld stays 0.
  - Set err=1 and data=0; go to RESP.
- ISSUE, normal case: drive cfg_req_vld=1 for exactly one cycle, with cfg_data_rb_w/cfg_addr/cfg_data from the latched values.
  - Write: go to RESP, err=0.
  - Read: go to WAIT_RD and clear the counter.
- cfg_addr/cfg_data/cfg_data_rb_w hold their last values outside ISSUE. They are only meaningful while cfg_req_vld=1.
- WAIT_RD:
  - cfg_data_rd_vld is sampled only in this state. A level asserted from an earlier transaction is accepted, so downstream rd_data must already be updated by the first WAIT_RD cycle.
  - On rd_vld: capture cfg_rd_data, err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT: data=0, err=1, go to RESP.
- RESP:
  - Pulse rsp_vld[owner]; rsp_data and rsp_err are valid this cycle only (0 otherwise).
  - Set rr_ptr = (owner+1) mod NUM_REQ; go to IDLE.
- Latency, grant cycle = T:
  - Write or error: ISSUE at T+1, RESP at T+2.
  - Read: RESP one cycle after the cycle in which cfg_data_rd_vld is sampled high. Best case is RESP at T+3.
- Minimum spacing between grants is 3 cycles.
- Requester rules: a requester may drop req_vld after its grant. A requester whose req_vld falls before grant is simply not considered.
- cfg_locked is sampled in ISSUE. A lock change after ISSUE does not affect a transaction in flight.
- Reset mid-transaction aborts it with no response; the downstream register block is reset by the same rst_n.

Optional Feature:
- Macro: SVM_CFG_ARB_HOST_PRIO_EN.
- Defined: requester 0 (host) has strict priority. When req_vld[0]=1 in IDLE it is always granted. Remaining requesters use round-robin among themselves; rr_ptr skips index 0.
- Undefined: pure round-robin over all NUM_REQ requesters, as described above.

Test Plan:
- Single write: req_vld[1]=1, rb_w=1, addr=3, wdata=0x1234, cfg_locked=0 -> gnt[1] at T; cfg_req_vld at T+1 with addr 3 / data 0x1234; rsp_vld[1] at T+2, err=0.
- Read: req 0 reads addr 6; cfg_data_rd_vld=1 with rd_data=2 in the first WAIT_RD cycle -> rsp_vld[0] one cycle later, rsp_data=2, err=0.
- Round-robin: all three req_vld held high, rr_ptr=0 -> grants in order 0,1,2,0 at 3-cycle spacing for writes. With SVM_CFG_ARB_HOST_PRIO_EN -> order 0,0,0...
- Errors:
  - Write to addr 9 with cfg_locked=1 -> no cfg_req_vld; rsp err=1 at T+2.
  - Read of addr 17 -> no cfg_req_vld; err=1, data=0.
- Timeout: read issued, cfg_data_rd_vld held 0 -> rsp err=1, data=0 after 15 WAIT_RD cycles. The next request is then granted normally.
- Reset mid-read: assert rst_n=0 in WAIT_RD -> all outputs 0 immediately; after release, no stale rsp_vld and rr_ptr=0.
